sipo_frame_receiver: RTL and testbench
======================================

// Module: sipo_frame_receiver
//
// PURPOSE
//   Serial-in, parallel-out frame receiver: the receiving end of a serial
//   data link fed by a PISO transmitter. Samples a strobed serial bit stream,
//   aligns to a start marker and assembles WIDTH-bit words. Hands each word
//   to a downstream consumer over a valid/ready interface through a
//   one-word holding register, so the next frame shifts in during the wait.
//
// PARAMETERS
//   WIDTH      8   bits per frame/word (>= 2)
//   MSB_FIRST  1   1: first received bit lands in po[WIDTH-1]; 0: in po[0]
//
// PORTS
//   clk        in   1      clock, all logic on posedge
//   rst        in   1      synchronous reset, active-high
//   si         in   1      serial data bit
//   si_valid   in   1      si is a valid bit this cycle
//   si_start   in   1      qualified by si_valid: this bit is bit 0 of a frame
//   po         out  WIDTH  received word (holding register)
//   po_valid   out  1      po holds an unconsumed word
//   po_ready   in   1      consumer accepts po this cycle
//   busy       out  1      a frame is partially received
//   overrun    out  1      1-cycle pulse: completed word dropped
//
// BEHAVIOUR
//   Reset (rst=1 at posedge, any state): po=0, po_valid=0, busy=0,
//     overrun=0, bit counter=0, shift register=0, state=IDLE.
//     A partial frame or an unconsumed word is discarded.
//   States: IDLE, SHIFT. busy = (state==SHIFT).
//   IDLE: si_valid&&si_start -> sample si as bit 0, count=1, go SHIFT.
//     si_valid without si_start -> bit ignored. si_valid=0 -> no change.
//   SHIFT: si_valid=0 -> hold (no timeout; gaps of any length allowed).
//     si_valid&&!si_start -> shift si in, count+1.
//     si_valid&&si_start -> resync: partial frame discarded, si is new bit 0,
//     count=1, stay SHIFT. No overrun, no error flag.
//   Shift direction: MSB_FIRST=1 -> sr <= {sr[WIDTH-2:0], si};
//     MSB_FIRST=0 -> sr <= {si, sr[WIDTH-1:1]}.
//   Completion: the cycle the WIDTH-th bit is sampled (count==WIDTH-1 and
//     si_valid) is the completion cycle; state -> IDLE, count -> 0.
//     Latency: po/po_valid update at the same posedge that samples the
//     last bit (word visible in the cycle after the completion cycle).
//   Holding register load on completion:
//     - po_valid=0                -> po <= word, po_valid <= 1.
//     - po_valid=1 and po_ready=1 -> old word consumed, po <= new word,
//                                    po_valid stays 1 (back-to-back).
//     - po_valid=1 and po_ready=0 -> new word dropped, po unchanged,
//                                    overrun=1 for exactly one cycle.
//   Handshake: transfer when po_valid&&po_ready at posedge; without a load
//     that cycle po_valid <= 0 and po keeps its value. po_ready while
//     po_valid=0 has no effect. po stable while po_valid=1 and not consumed.
//   si_start coinciding with completion: the bit is a resync bit 0 (the
//     frame is NOT completed); completion needs si_start=0 on the last bit.
//   Counter width: $clog2(WIDTH)+1 bits; never exceeds WIDTH-1.
//
// TESTING  (WIDTH=8, MSB_FIRST=1 unless noted)
//   1 Reset: rst=1 for 2 cycles mid-frame -> po=0, po_valid=0, busy=0,
//     overrun=0; next frame received cleanly from its start bit.
//   2 Single frame 1,0,1,0,0,1,0,1 (start on bit 0), po_ready=0 -> po=8'hA5,
//     po_valid=1 one posedge after last bit; holds until po_ready=1, then
//     po_valid=0 next cycle.
//   3 si_valid gaps of 0..5 cycles between bits of 8'h3C -> po=8'h3C; busy=1
//     throughout; bits with si_valid=0 ignored.
//   4 Resync: 4 bits, then si_start with frame 8'hF0 -> po=8'hF0, no overrun.
//   5 Two frames 8'h11, 8'h22 with po_ready=0 -> po=8'h11, overrun pulses 1
//     cycle at second completion; repeat with po_ready=1 held -> both
//     words delivered in order, po_valid continuous across the load.
//   6 MSB_FIRST=0, bits 1,0,1,0,0,1,0,1 -> po=8'hA5 bit-reversed = 8'hA5
//     check with 8'h01 pattern: first bit 1 then 0s -> po=8'h01.

Source files
------------

// File: rtl/sipo_frame_receiver.sv
// Serial-in, parallel-out frame receiver with a one-word output holding register.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | waiting for a start-qualified bit (bit 0 of a frame)
//  SHIFT | frame partially received, collecting the remaining bits
module sipo_frame_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_valid,
    input  logic             si_start,
    output logic [WIDTH-1:0] po,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] po_nxt;
    logic             po_valid_nxt;
    logic             overrun_nxt;
    logic             complete;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] start_word;

    // A start bit lands in an otherwise cleared register so no stale bits survive a resync.
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted    = {sr[WIDTH-2:0], si};
            assign start_word = {{(WIDTH-1){1'b0}}, si};
        end else begin : g_lsb
            assign shifted    = {si, sr[WIDTH-1:1]};
            assign start_word = {si, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    assign busy = (state == SHIFT);

    // State, shift register, holding register and overrun pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            sr       <= '0;
            po       <= '0;
            po_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            sr       <= sr_nxt;
            po       <= po_nxt;
            po_valid <= po_valid_nxt;
            overrun  <= overrun_nxt;
        end
    end

    // Frame alignment, bit counting and hand-off to the holding register.
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        sr_nxt       = sr;
        complete     = 1'b0;
        po_nxt       = po;
        po_valid_nxt = po_valid;
        overrun_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (si_valid && si_start) begin
                    sr_nxt    = start_word;
                    count_nxt = CW'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (si_valid) begin
                    if (si_start) begin
                        // Resync: the partial frame is silently abandoned.
                        sr_nxt    = start_word;
                        count_nxt = CW'(1);
                    end else if (count == LAST) begin
                        sr_nxt    = shifted;
                        count_nxt = '0;
                        state_nxt = IDLE;
                        complete  = 1'b1;
                    end else begin
                        sr_nxt    = shifted;
                        count_nxt = count + CW'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase

        if (complete) begin
            // A word still waiting and not taken this cycle wins; the new one is dropped.
            if (!po_valid || po_ready) begin
                po_nxt       = shifted;
                po_valid_nxt = 1'b1;
            end else begin
                overrun_nxt  = 1'b1;
            end
        end else if (po_valid && po_ready) begin
            po_valid_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver: MSB-first and LSB-first instances share stimulus.
module tb_sipo_frame_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       si;
    logic       si_valid;
    logic       si_start;
    logic       po_ready;
    logic [7:0] po, po_l;
    logic       po_valid, po_valid_l;
    logic       busy, busy_l;
    logic       overrun, overrun_l;

    int         checks = 0;
    int         errors = 0;
    int         ov_cnt = 0;
    logic [7:0] acc_q[$];
    logic       busy_bad;

    sipo_frame_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .si_start(si_start),
        .po(po), .po_valid(po_valid), .po_ready(po_ready), .busy(busy), .overrun(overrun)
    );

    sipo_frame_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .si(si), .si_valid(si_valid), .si_start(si_start),
        .po(po_l), .po_valid(po_valid_l), .po_ready(po_ready), .busy(busy_l), .overrun(overrun_l)
    );

    always #5 clk = ~clk;

    // Count overrun cycles and log words accepted by the consumer.
    always @(posedge clk) begin
        if (overrun) ov_cnt++;
        if (po_valid && po_ready) acc_q.push_back(po);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one strobed bit; called and returns at a negedge.
    task automatic send_bit(input logic b, input logic st);
        si       = b;
        si_valid = 1'b1;
        si_start = st;
        @(negedge clk);
        si_valid = 1'b0;
        si_start = 1'b0;
    endtask

    // Bits go out w[7] first; the MSB-first instance reassembles w.
    task automatic send_frame(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], i == 7);
    endtask

    task automatic consume();
        po_ready = 1'b1;
        @(negedge clk);
        po_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        rst = 1'b0; si = 1'b0; si_valid = 1'b0; si_start = 1'b0; po_ready = 1'b0;
        @(negedge clk);
        do_reset();
        chk("reset_po_valid", po_valid, 0);

        // 1: reset mid-frame with a word held
        send_frame(8'hA5);
        chk("pre_reset_po", po, 8'hA5);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("pre_reset_busy", busy, 1);
        do_reset();
        chk("rst_po", po, 0);
        chk("rst_po_valid", po_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        send_frame(8'h5A);
        chk("post_reset_po", po, 8'h5A);
        chk("post_reset_valid", po_valid, 1);
        consume();
        chk("post_reset_consumed", po_valid, 0);

        // 2: single frame, holding until consumed
        w = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(w[i], i == 7);
        chk("t2_valid_before_last", po_valid, 0);
        chk("t2_busy_before_last", busy, 1);
        send_bit(w[0], 1'b0);
        chk("t2_po", po, 8'hA5);
        chk("t2_valid", po_valid, 1);
        chk("t2_busy_after", busy, 0);
        repeat (3) @(negedge clk);
        chk("t2_hold_po", po, 8'hA5);
        chk("t2_hold_valid", po_valid, 1);
        consume();
        chk("t2_consumed_valid", po_valid, 0);
        chk("t2_consumed_po", po, 8'hA5);

        // 3: gaps of 0..5 cycles; bits presented without si_valid are inverted decoys
        w = 8'h3C;
        busy_bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_bit(w[7-i], i == 0);
            if (i < 7) begin
                for (int g = 0; g < (i % 6); g++) begin
                    si = ~w[6-i];
                    si_start = 1'b1;
                    if (!busy) busy_bad = 1'b1;
                    @(negedge clk);
                    si_start = 1'b0;
                end
            end
        end
        chk("t3_busy_in_gaps", busy_bad, 0);
        chk("t3_po", po, 8'h3C);
        chk("t3_valid", po_valid, 1);
        consume();

        // 4: resync after 4 bits
        ov_cnt = 0;
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("t4_partial_busy", busy, 1);
        send_frame(8'hF0);
        @(negedge clk);
        chk("t4_po", po, 8'hF0);
        chk("t4_valid", po_valid, 1);
        chk("t4_no_overrun", ov_cnt, 0);
        consume();

        // 5a: second word dropped while first is held
        ov_cnt = 0;
        send_frame(8'h11);
        send_frame(8'h22);
        chk("t5_overrun_pulse", overrun, 1);
        chk("t5_po_kept", po, 8'h11);
        @(negedge clk);
        chk("t5_overrun_cleared", overrun, 0);
        chk("t5_overrun_cycles", ov_cnt, 1);
        consume();

        // 5b: consumer always ready, words arrive in order
        acc_q.delete();
        ov_cnt = 0;
        po_ready = 1'b1;
        send_frame(8'h11);
        chk("t5b_po1", po, 8'h11);
        send_frame(8'h22);
        chk("t5b_po2", po, 8'h22);
        chk("t5b_valid2", po_valid, 1);
        @(negedge clk);
        po_ready = 1'b0;
        chk("t5b_acc_count", acc_q.size(), 2);
        if (acc_q.size() == 2) begin
            chk("t5b_acc0", acc_q[0], 8'h11);
            chk("t5b_acc1", acc_q[1], 8'h22);
        end
        chk("t5b_no_overrun", ov_cnt, 0);

        // 5c: consume and reload in the same cycle
        send_frame(8'h11);
        w = 8'h22;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) po_ready = 1'b1;
            send_bit(w[i], i == 7);
        end
        po_ready = 1'b0;
        chk("t5c_po", po, 8'h22);
        chk("t5c_valid_continuous", po_valid, 1);
        @(negedge clk);
        chk("t5c_valid_held", po_valid, 1);
        chk("t5c_no_overrun", ov_cnt, 0);
        consume();

        // 6: LSB-first instance
        do_reset();
        send_frame(8'hA5);
        chk("t6_lsb_a5", po_l, 8'hA5);
        chk("t6_lsb_valid", po_valid_l, 1);
        consume();
        send_frame(8'h80);
        chk("t6_lsb_01", po_l, 8'h01);
        chk("t6_msb_80", po, 8'h80);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
